sig_display: RTL and testbench



---
 rtl/sigan_pkg.sv | 60 ++++++
 rtl/led_stretch.sv | 28 ++
 rtl/sig_display.sv | 113 +++++++++++
 tb/tb_sig_display.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sigan_pkg.sv
// Shared display definitions for the signature analyzer readouts: HP hex glyphs and display payload.
package sigan_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned SIG_W  = NIB_W * DIGITS;

  typedef logic [SEG_W-1:0] seg_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_A    = 7'h77;
  localparam seg_t SEG_C    = 7'h39;
  localparam seg_t SEG_F    = 7'h71;
  localparam seg_t SEG_H    = 7'h76;
  localparam seg_t SEG_P    = 7'h73;
  localparam seg_t SEG_U    = 7'h3E;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  typedef struct packed {
    seg_t              seg;
    logic [DIGITS-1:0] digit_en;
  } disp_t;

  // HP signature charset: nibbles 10..15 render as A, C, F, H, P, U
  function automatic seg_t hp_glyph(input logic [NIB_W-1:0] nib);
    seg_t g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      4'd10:   g = SEG_A;
      4'd11:   g = SEG_C;
      4'd12:   g = SEG_F;
      4'd13:   g = SEG_H;
      4'd14:   g = SEG_P;
      default: g = SEG_U;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/led_stretch.sv
// Pulse stretcher: trigger loads the counter; led is lit while counting or while 'lit' is high.
module led_stretch #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned LOAD  = 1 << 20
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger,
  input  logic lit,
  output logic led
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      led   <= 1'b0;
    end else begin
      if (trigger)
        count <= WIDTH'(LOAD);
      else if (count != '0)
        count <= count - WIDTH'(1);
      led <= lit | (count != '0);
    end
  end

endmodule

// File: rtl/sig_display.sv
// Signature capture and 4-digit multiplexed HP-hex display with unstable and gate LEDs.
// Optional SIG_DISPLAY_HOLD_EN adds a 'hold' input that freezes the captured signature.
module sig_display
  import sigan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned STRETCH      = 1 << 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SIG_W-1:0]  sig_in,
  input  logic              sig_strobe,
  input  logic              gate_active,
`ifdef SIG_DISPLAY_HOLD_EN
  input  logic              hold,
`endif
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] digit_en,
  output logic              valid,
  output logic              unstable,
  output logic              gate_led
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STR_W = $clog2(STRETCH + 1);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic [SIG_W-1:0] shown;
  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] index;
  logic             accept_c;
  logic             differ_c;
  logic [NIB_W-1:0] nibble_c;
  disp_t            disp_c;

`ifdef SIG_DISPLAY_HOLD_EN
  assign accept_c = sig_strobe & ~hold;
`else
  assign accept_c = sig_strobe;
`endif

  // First capture after reset only establishes the reference value
  assign differ_c = accept_c & valid & (sig_in != shown);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shown <= '0;
      valid <= 1'b0;
    end else if (accept_c) begin
      shown <= sig_in;
      valid <= 1'b1;
    end
  end

  // Digit slots run leftmost first: 3, 2, 1, 0, 3, ...
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      index     <= IDX_W'(DIGITS - 1);
    end else if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      index     <= index - IDX_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  assign nibble_c = shown[{index, 2'b00} +: NIB_W];

  always_comb begin
    disp_c.seg      = SEG_DASH;
    disp_c.digit_en = '0;
    if (valid)
      disp_c.seg = hp_glyph(nibble_c);
    if (prescaler >= PRE_W'(BLANK_CYCLES))
      disp_c.digit_en = DIGITS'(1) << index;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg      <= SEG_OFF;
      digit_en <= '0;
    end else begin
      seg      <= disp_c.seg;
      digit_en <= disp_c.digit_en;
    end
  end

  led_stretch #(
    .WIDTH (STR_W),
    .LOAD  (STRETCH)
  ) u_unstable (
    .clock   (clock),
    .reset   (reset),
    .trigger (differ_c),
    .lit     (1'b0),
    .led     (unstable)
  );

  // Gate input both reloads the counter and lights the LED directly
  led_stretch #(
    .WIDTH (STR_W),
    .LOAD  (STRETCH)
  ) u_gate (
    .clock   (clock),
    .reset   (reset),
    .trigger (gate_active),
    .lit     (gate_active),
    .led     (gate_led)
  );

endmodule

// File: tb/tb_sig_display.sv
// Directed bench for sig_display with a short scan and stretch (SCAN_DIV=8, BLANK_CYCLES=2, STRETCH=16).
module tb_sig_display;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned ST = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] sig_in;
  logic        sig_strobe;
  logic        gate_active;
`ifdef SIG_DISPLAY_HOLD_EN
  logic        hold;
`endif
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        valid;
  logic        unstable;
  logic        gate_led;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Hand-derived glyphs per digit index [3:0]
  logic [6:0] exp_1fa9 [3:0];
  logic [6:0] exp_cdef [3:0];

  always #5 clock = ~clock;

  sig_display #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .STRETCH      (ST)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .sig_strobe  (sig_strobe),
    .gate_active (gate_active),
`ifdef SIG_DISPLAY_HOLD_EN
    .hold        (hold),
`endif
    .seg         (seg),
    .digit_en    (digit_en),
    .valid       (valid),
    .unstable    (unstable),
    .gate_led    (gate_led)
  );

  task automatic tick();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  // Scan position seen by the output stage at edge n (n >= 1 since reset release)
  function automatic int pre_at(input int n);
    return (n - 1) % SD;
  endfunction

  function automatic int idx_at(input int n);
    return 3 - (((n - 1) / SD) % 4);
  endfunction

  function automatic logic [3:0] en_at(input int n);
    if (pre_at(n) < BC) return 4'b0000;
    return 4'(1 << idx_at(n));
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (seg !== 7'h00)      begin errors++; $display("FAIL reset_seg: got %h expected 00", seg); end
    checks++; if (digit_en !== 4'h0)  begin errors++; $display("FAIL reset_digit_en: got %h expected 0", digit_en); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (unstable !== 1'b0)  begin errors++; $display("FAIL reset_unstable: got %b expected 0", unstable); end
    checks++; if (gate_led !== 1'b0)  begin errors++; $display("FAIL reset_gate_led: got %b expected 0", gate_led); end
    tick();
    tick();
    checks++; if (digit_en !== 4'h0)  begin errors++; $display("FAIL reset_held_digit_en: got %h expected 0", digit_en); end
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (digit_en !== en_at(edge_n)) begin errors++; $display("FAIL idle_digit_en@%0d: got %h expected %h", edge_n, digit_en, en_at(edge_n)); end
      checks++; if (seg !== 7'h40) begin errors++; $display("FAIL idle_seg@%0d: got %h expected 40", edge_n, seg); end
    end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL idle_valid: got %b expected 0", valid); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL idle_unstable: got %b expected 0", unstable); end
  endtask

  task automatic test_capture();
    sig_in     = 16'h1FA9;
    sig_strobe = 1'b1;
    tick();
    sig_strobe = 1'b0;
    checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL capture_valid: got %b expected 1", valid); end
    checks++; if (seg !== 7'h40)   begin errors++; $display("FAIL capture_latency_seg: got %h expected 40", seg); end
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (seg !== exp_1fa9[idx_at(edge_n)]) begin errors++; $display("FAIL capture_seg@%0d: got %h expected %h", edge_n, seg, exp_1fa9[idx_at(edge_n)]); end
      checks++; if (digit_en !== en_at(edge_n)) begin errors++; $display("FAIL capture_digit_en@%0d: got %h expected %h", edge_n, digit_en, en_at(edge_n)); end
      checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL capture_unstable@%0d: got %b expected 0", edge_n, unstable); end
    end
  endtask

  task automatic test_unstable();
    bit found = 1'b0;
    sig_in     = 16'h1FA9;
    sig_strobe = 1'b1;
    tick();
    sig_strobe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL repeat_unstable@%0d: got %b expected 0", i, unstable); end
    end
    // Line up the differing strobe with the middle of digit 0's slot
    for (int i = 0; i < 64 && !found; i++) begin
      if (pre_at(edge_n + 1) == 4 && idx_at(edge_n + 1) == 0) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL align_slot: got none expected slot 0 phase 4"); end
    sig_in     = 16'h1FAA;
    sig_strobe = 1'b1;
    tick();
    sig_strobe = 1'b0;
    checks++; if (unstable !== 1'b0)  begin errors++; $display("FAIL differ_unstable_edge: got %b expected 0", unstable); end
    checks++; if (seg !== 7'h6F)      begin errors++; $display("FAIL midslot_old_seg: got %h expected 6f", seg); end
    checks++; if (digit_en !== 4'h1)  begin errors++; $display("FAIL midslot_digit_en: got %h expected 1", digit_en); end
    tick();
    checks++; if (seg !== 7'h77)      begin errors++; $display("FAIL midslot_new_seg: got %h expected 77", seg); end
    checks++; if (digit_en !== 4'h1)  begin errors++; $display("FAIL midslot_no_reblank: got %h expected 1", digit_en); end
    checks++; if (unstable !== 1'b1)  begin errors++; $display("FAIL differ_unstable_1: got %b expected 1", unstable); end
    for (int k = 2; k <= 16; k++) begin
      tick();
      checks++; if (unstable !== 1'b1) begin errors++; $display("FAIL differ_unstable_%0d: got %b expected 1", k, unstable); end
    end
    tick();
    checks++; if (unstable !== 1'b0)  begin errors++; $display("FAIL differ_unstable_end: got %b expected 0", unstable); end
  endtask

  task automatic test_gate();
    checks++; if (gate_led !== 1'b0) begin errors++; $display("FAIL gate_idle: got %b expected 0", gate_led); end
    gate_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (gate_led !== 1'b1) begin errors++; $display("FAIL gate_open_%0d: got %b expected 1", i, gate_led); end
    end
    gate_active = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (gate_led !== 1'b1) begin errors++; $display("FAIL gate_stretch_%0d: got %b expected 1", k, gate_led); end
    end
    tick();
    checks++; if (gate_led !== 1'b0) begin errors++; $display("FAIL gate_stretch_end: got %b expected 0", gate_led); end
  endtask

  task automatic test_same_cycle();
    sig_in      = 16'h1FAB;
    sig_strobe  = 1'b1;
    gate_active = 1'b1;
    tick();
    sig_strobe = 1'b0;
    checks++; if (gate_led !== 1'b1) begin errors++; $display("FAIL same_gate_led: got %b expected 1", gate_led); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL same_unstable_edge: got %b expected 0", unstable); end
    tick();
    checks++; if (unstable !== 1'b1) begin errors++; $display("FAIL same_unstable: got %b expected 1", unstable); end
    checks++; if (gate_led !== 1'b1) begin errors++; $display("FAIL same_gate_held: got %b expected 1", gate_led); end
    gate_active = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (seg !== 7'h00)     begin errors++; $display("FAIL mid_reset_seg: got %h expected 00", seg); end
    checks++; if (digit_en !== 4'h0) begin errors++; $display("FAIL mid_reset_digit_en: got %h expected 0", digit_en); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", valid); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL mid_reset_unstable: got %b expected 0", unstable); end
    checks++; if (gate_led !== 1'b0) begin errors++; $display("FAIL mid_reset_gate_led: got %b expected 0", gate_led); end
    @(negedge clock);
    reset  = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (digit_en !== en_at(edge_n)) begin errors++; $display("FAIL restart_digit_en@%0d: got %h expected %h", edge_n, digit_en, en_at(edge_n)); end
      checks++; if (seg !== 7'h40) begin errors++; $display("FAIL restart_seg@%0d: got %h expected 40", edge_n, seg); end
    end
  endtask

`ifdef SIG_DISPLAY_HOLD_EN
  task automatic test_hold();
    sig_in     = 16'h1FA9;
    sig_strobe = 1'b1;
    tick();
    hold       = 1'b1;
    sig_in     = 16'hCDEF;
    tick();
    sig_strobe = 1'b0;
    tick();
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL hold_unstable: got %b expected 0", unstable); end
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (seg !== exp_1fa9[idx_at(edge_n)]) begin errors++; $display("FAIL hold_seg@%0d: got %h expected %h", edge_n, seg, exp_1fa9[idx_at(edge_n)]); end
    end
    hold       = 1'b0;
    sig_strobe = 1'b1;
    tick();
    sig_strobe = 1'b0;
    tick();
    checks++; if (unstable !== 1'b1) begin errors++; $display("FAIL release_unstable: got %b expected 1", unstable); end
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (seg !== exp_cdef[idx_at(edge_n)]) begin errors++; $display("FAIL release_seg@%0d: got %h expected %h", edge_n, seg, exp_cdef[idx_at(edge_n)]); end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_1fa9    = '{7'h06, 7'h3E, 7'h77, 7'h6F};
    exp_cdef    = '{7'h71, 7'h76, 7'h73, 7'h3E};
    reset       = 1'b0;
    sig_in      = '0;
    sig_strobe  = 1'b0;
    gate_active = 1'b0;
`ifdef SIG_DISPLAY_HOLD_EN
    hold        = 1'b0;
`endif
    test_reset();
    test_idle_scan();
    test_capture();
    test_unstable();
    test_gate();
    test_same_cycle();
    test_reset_mid();
`ifdef SIG_DISPLAY_HOLD_EN
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
